// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants, types and helpers for the register bank.
//   NUM_REGS  : architectural register count (index 31 is XZR)
//   DATA_W    : architectural register width
//   XZR_IDX   : index of the hardwired-zero register
//   reg_word_t: one architectural register word
//   sat_inc16 : 16-bit increment that sticks at all-ones
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int XZR_IDX  = 31;
  localparam int IDX_W    = 5;

  typedef logic [63:0] reg_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// regfile_bank_if -- write-back bus into the register bank.
//   RegWrite      : write enable from the WB stage
//   WriteRegister : destination register index
//   WriteData     : value to write
// Modports: master drives the bus (WB stage / testbench), slave receives it.
interface regfile_bank_if #(
  parameter int DATA_W = 64
);

  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData
  );

  modport slave (
    input RegWrite,
    input WriteRegister,
    input WriteData
  );

endinterface

// File: rtl/regfile_bank_decoder5_32.sv
// decoder5_32 -- 5-bit index plus enable to 32-bit one-hot vector.
//   idx    : input, register index
//   en     : input, enable; when low the output is all zeros
//   onehot : output, at most one bit set (bit idx when en=1)
// An unknown idx with en=0 still yields all zeros, so a stalled WB stage
// with a garbage index cannot produce a write.
module decoder5_32 (
  input  logic [4:0]  idx,
  input  logic        en,
  output logic [31:0] onehot
);

  import regfile_pkg::*;

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/regfile_bank.sv
// regfile_bank -- 32 x 64-bit architectural register file, register 31 = XZR.
//   clk         : single clock, all state updates on rising edge
//   reset       : synchronous active-high reset
//   wr_if       : write-back bus (regfile_bank_if.slave)
//   regs_out    : every register value, feeding the read-port muxes
//   reg_valid   : per-register written-since-reset flag (bit 31 always 1)
//   write_count : committed writes since reset, saturating at 16'hFFFF
// Build option REGFILE_BYPASS_EN: when defined, a committed write is also
// forwarded combinationally onto regs_out in the write cycle. When undefined
// (default) regs_out reflects stored state only, one cycle after the write.
module regfile_bank #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  regfile_bank_if.slave                      wr_if,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    regs_out,
  output logic [NUM_REGS-1:0]                reg_valid,
  output logic [15:0]                        write_count
);

  import regfile_pkg::*;

  logic [31:0]       we;
  logic              write_commit;
  logic [DATA_W-1:0] stored [NUM_REGS-1];

  logic [NUM_REGS-2:0] valid_d, valid_q;
  logic [15:0]         count_d, count_q;

  decoder5_32 u_dec (
    .idx    (wr_if.WriteRegister),
    .en     (wr_if.RegWrite),
    .onehot (we)
  );

  // With RegWrite=1 exactly one decoder bit is set, so the write commits
  // unless that bit is the XZR slot.
  assign write_commit = wr_if.RegWrite & ~we[XZR_IDX];

  // Storage for registers 0..30; XZR has no flops at all.
  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
    logic [DATA_W-1:0] word_d, word_q;

    always_comb begin
      word_d = word_q;
      if (reset) begin
        word_d = '0;
      end else if (we[i]) begin
        word_d = wr_if.WriteData;
      end
    end

    always_ff @(posedge clk) begin
      word_q <= word_d;
    end

    assign stored[i] = word_q;
  end

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (reset) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      valid_d = valid_q | we[NUM_REGS-2:0];
      if (write_commit) begin
        count_d = sat_inc16(count_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    count_q <= count_d;
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      regs_out[i] = stored[i];
    end
`ifdef REGFILE_BYPASS_EN
    // Same-cycle write-then-read: forward the value being written.
    if (!reset) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (we[i]) begin
          regs_out[i] = wr_if.WriteData;
        end
      end
    end
`endif
    regs_out[XZR_IDX] = '0;
  end

  assign reg_valid   = {1'b1, valid_q};
  assign write_count = count_q;

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank -- randomized self-checking bench for regfile_bank with a
// behavioural model (array of words, valid flags, saturating counter).
module tb_regfile_bank;

  logic clk;
  logic reset;
  logic [31:0][63:0] regs_out;
  logic [31:0]       reg_valid;
  logic [15:0]       write_count;

  regfile_bank_if #(.DATA_W(64)) bus ();

  regfile_bank #(.DATA_W(64), .NUM_REGS(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_if       (bus),
    .regs_out    (regs_out),
    .reg_valid   (reg_valid),
    .write_count (write_count)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] m_reg [32];
  logic        m_valid [32];
  int          m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_valid();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_valid[i];
    v[31] = 1'b1;
    return v;
  endfunction

  // One clock cycle of stimulus; model follows the architectural rules.
  task automatic cycle(input logic rst_i, input logic we_i,
                       input logic [4:0] idx_i, input logic [63:0] d_i);
    reset             = rst_i;
    bus.RegWrite      = we_i;
    bus.WriteRegister = idx_i;
    bus.WriteData     = d_i;
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]   = 64'h0;
        m_valid[i] = 1'b0;
      end
      m_cnt = 0;
    end else if (we_i && idx_i != 5'd31) begin
      m_reg[idx_i]   = d_i;
      m_valid[idx_i] = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
    #1;
    reset        = 1'b0;
    bus.RegWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.WriteRegister = 'x;
    cycle(1'b1, 1'b0, 5'd0, 64'h0);
    cycle(1'b0, 1'b0, 5'd0, 64'h0);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (regs_out[i] !== 64'h0) begin
        bad++; $display("FAIL reset_reg[%0d]: got %h want 0", i, regs_out[i]);
      end
    end
    total++;
    if (reg_valid !== 32'h8000_0000) begin
      bad++; $display("FAIL reset_valid: got %h want 80000000", reg_valid);
    end
    total++;
    if (write_count !== 16'h0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", write_count);
    end
  endtask

  task automatic test_single_write();
    cycle(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0123_4567);
    total++;
    if (regs_out[5] !== 64'hDEAD_BEEF_0123_4567) begin
      bad++; $display("FAIL x5_value: got %h want deadbeef01234567", regs_out[5]);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == 5) continue;
      total++;
      if (regs_out[i] !== 64'h0) begin
        bad++; $display("FAIL x5_others[%0d]: got %h want 0", i, regs_out[i]);
      end
    end
    total++;
    if (reg_valid !== 32'h8000_0020) begin
      bad++; $display("FAIL x5_valid: got %h want 80000020", reg_valid);
    end
    total++;
    if (write_count !== 16'd1) begin
      bad++; $display("FAIL x5_count: got %0d want 1", write_count);
    end
  endtask

  task automatic test_xzr();
    cycle(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (regs_out[i] !== m_reg[i]) begin
        bad++; $display("FAIL xzr_reg[%0d]: got %h want %h", i, regs_out[i], m_reg[i]);
      end
    end
    total++;
    if (write_count !== 16'd1) begin
      bad++; $display("FAIL xzr_count: got %0d want 1", write_count);
    end
    total++;
    if (reg_valid !== 32'h8000_0020) begin
      bad++; $display("FAIL xzr_valid: got %h want 80000020", reg_valid);
    end
  endtask

  task automatic test_reset_priority();
    cycle(1'b1, 1'b1, 5'd7, 64'h1);
    total++;
    if (regs_out[7] !== 64'h0) begin
      bad++; $display("FAIL rstprio_x7: got %h want 0", regs_out[7]);
    end
    total++;
    if (reg_valid[7] !== 1'b0) begin
      bad++; $display("FAIL rstprio_valid7: got %b want 0", reg_valid[7]);
    end
    total++;
    if (write_count !== 16'd0) begin
      bad++; $display("FAIL rstprio_count: got %0d want 0", write_count);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 5'd0, 64'hA);
    // Second write: look at regs_out inside the write cycle.
    reset             = 1'b0;
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 64'hB;
    #1;
    total++;
`ifdef REGFILE_BYPASS_EN
    if (regs_out[0] !== 64'hB) begin
      bad++; $display("FAIL b2b_bypass: got %h want b", regs_out[0]);
    end
`else
    if (regs_out[0] !== 64'hA) begin
      bad++; $display("FAIL b2b_no_bypass: got %h want a", regs_out[0]);
    end
`endif
    cycle(1'b0, 1'b1, 5'd0, 64'hB);
    total++;
    if (regs_out[0] !== 64'hB) begin
      bad++; $display("FAIL b2b_x0: got %h want b", regs_out[0]);
    end
    total++;
    if (write_count !== 16'd2) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", write_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic        r;
      logic        w;
      logic [4:0]  ix;
      logic [63:0] d;
      r  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 3) != 0);
      ix = 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      cycle(r, w, ix, d);
      for (int i = 0; i < 32; i++) begin
        total++;
        if (regs_out[i] !== m_reg[i]) begin
          bad++; $display("FAIL rand_reg[%0d] step %0d: got %h want %h", i, n, regs_out[i], m_reg[i]);
        end
      end
      total++;
      if (reg_valid !== exp_valid()) begin
        bad++; $display("FAIL rand_valid step %0d: got %h want %h", n, reg_valid, exp_valid());
      end
      total++;
      if (write_count !== 16'(m_cnt)) begin
        bad++; $display("FAIL rand_count step %0d: got %0d want %0d", n, write_count, m_cnt);
      end
    end
  endtask

  task automatic test_sweep_reset();
    cycle(1'b1, 1'b0, 5'd0, 64'h0);
    for (int k = 0; k < 15; k++) cycle(1'b0, 1'b1, 5'(k), 64'(k));
    total++;
    if (write_count !== 16'd15) begin
      bad++; $display("FAIL sweep_pre_count: got %0d want 15", write_count);
    end
    // Reset lands together with the write of X15.
    cycle(1'b1, 1'b1, 5'd15, 64'd15);
    for (int i = 0; i < 32; i++) begin
      total++;
      if (regs_out[i] !== 64'h0) begin
        bad++; $display("FAIL sweep_rst_reg[%0d]: got %h want 0", i, regs_out[i]);
      end
    end
    total++;
    if (reg_valid !== 32'h8000_0000) begin
      bad++; $display("FAIL sweep_rst_valid: got %h want 80000000", reg_valid);
    end
    for (int k = 16; k < 31; k++) cycle(1'b0, 1'b1, 5'(k), 64'(k));
    for (int i = 0; i < 32; i++) begin
      total++;
      if (regs_out[i] !== m_reg[i]) begin
        bad++; $display("FAIL sweep_resume_reg[%0d]: got %h want %h", i, regs_out[i], m_reg[i]);
      end
    end
    total++;
    if (reg_valid !== exp_valid()) begin
      bad++; $display("FAIL sweep_resume_valid: got %h want %h", reg_valid, exp_valid());
    end
    total++;
    if (write_count !== 16'd15) begin
      bad++; $display("FAIL sweep_resume_count: got %0d want 15", write_count);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] last;
    cycle(1'b1, 1'b0, 5'd0, 64'h0);
    last = 64'h0;
    for (int n = 1; n <= 65540; n++) begin
      last = {$urandom, $urandom};
      cycle(1'b0, 1'b1, 5'd1, last);
      if (n == 65534 || n == 65535 || n == 65536) begin
        total++;
        if (write_count !== 16'(m_cnt)) begin
          bad++; $display("FAIL sat_count_at_%0d: got %h want %h", n, write_count, 16'(m_cnt));
        end
      end
    end
    total++;
    if (write_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_final: got %h want ffff", write_count);
    end
    total++;
    if (regs_out[1] !== last) begin
      bad++; $display("FAIL sat_x1: got %h want %h", regs_out[1], last);
    end
    cycle(1'b0, 1'b0, 5'd1, 64'h0);
    total++;
    if (write_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold: got %h want ffff", write_count);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = 64'h0;
    for (int i = 0; i < 32; i++) begin
      m_reg[i]   = 64'h0;
      m_valid[i] = 1'b0;
    end
    m_cnt = 0;
    #2;
    test_reset();
    test_single_write();
    test_xzr();
    test_reset_priority();
    test_back_to_back();
    test_random();
    test_sweep_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
